data_sram_resp: RTL and testbench

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp.sv | 97 +++++++++
 tb/tb_data_sram_resp.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_resp.sv
// data_sram_resp: 2^ADDR_WIDTH x 32-bit data SRAM with byte write enables, one-cycle read-first
// response and a sticky out-of-range flag. Define DSRAM_PERF_CNT_EN to add rd_cnt/wr_cnt counters.
module data_sram_resp #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic        err_clr,
    output logic        err_oob
`ifdef DSRAM_PERF_CNT_EN
    ,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           r_mem [DEPTH];
    logic [31:0]           r_rdata;
    logic                  r_err_oob;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_in_range;
    logic                  w_oob;
    logic                  w_mem_wr;

    // Anything above the word-index bits must be zero; the byte offset bits never matter.
    assign w_in_range = (data_sram_addr >> (ADDR_WIDTH + 2)) == 32'h0;
    assign w_idx      = data_sram_addr[ADDR_WIDTH+1:2];
    assign w_oob      = data_sram_en & ~w_in_range;
    assign w_mem_wr   = resetn & data_sram_en & w_in_range;

    // Storage is deliberately not reset; resetn only blocks writes while it is low.
    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wen[b]) begin
                    r_mem[w_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata <= 32'h0;
        end else if (data_sram_en) begin
            r_rdata <= w_in_range ? r_mem[w_idx] : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err_oob <= 1'b0;
        end else if (w_oob) begin
            r_err_oob <= 1'b1;
        end else if (err_clr) begin
            r_err_oob <= 1'b0;
        end
    end

    assign data_sram_rdata = r_rdata;
    assign err_oob         = r_err_oob;

`ifdef DSRAM_PERF_CNT_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;
    logic        w_is_rd;
    logic        w_is_wr;

    assign w_is_rd = data_sram_en & (data_sram_wen == 4'h0);
    assign w_is_wr = data_sram_en & (data_sram_wen != 4'h0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_cnt <= 32'h0;
            r_wr_cnt <= 32'h0;
        end else begin
            if (w_is_rd && (r_rd_cnt != 32'hFFFF_FFFF)) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            if (w_is_wr && (r_wr_cnt != 32'hFFFF_FFFF)) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
        end
    end

    assign rd_cnt = r_rd_cnt;
    assign wr_cnt = r_wr_cnt;
`endif

endmodule

// File: tb/tb_data_sram_resp.sv
// Testbench for data_sram_resp: directed vector table, reset-in-flight sequence, and randomized
// traffic checked against a word-array reference model.
module tb_data_sram_resp;
    localparam int AW = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        err_clr;
    logic        err_oob;
`ifdef DSRAM_PERF_CNT_EN
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;
`endif

    always #5 clk = ~clk;

    data_sram_resp #(.ADDR_WIDTH(AW)) u_dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .err_clr         (err_clr),
        .err_oob         (err_oob)
`ifdef DSRAM_PERF_CNT_EN
        ,
        .rd_cnt          (rd_cnt),
        .wr_cnt          (wr_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: words keyed by word number, plus the expected output registers.
    logic [31:0] m_mem [int];
    logic [31:0] m_rdata;
    bit          m_rd_known;
    bit          m_err;
    longint      m_rd_cnt;
    longint      m_wr_cnt;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        clr;
        logic        chk;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tv [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rdata    = 32'h0;
        m_rd_known = 1'b1;
        m_err      = 1'b0;
        m_rd_cnt   = 0;
        m_wr_cnt   = 0;
    endtask

    task automatic model_edge(input logic en, input logic [3:0] wen, input logic [31:0] a,
                              input logic [31:0] wd, input logic clr);
        bit          inr = (64'(a) < (64'd1 << (AW + 2)));
        int          idx = int'(a / 4);
        logic [31:0] w;
        if (en) begin
            if (wen == 4'h0) m_rd_cnt++;
            else             m_wr_cnt++;
            if (inr) begin
                m_rd_known = m_mem.exists(idx);
                m_rdata    = m_rd_known ? m_mem[idx] : 32'hx;
                if (m_rd_known || wen == 4'hF) begin
                    w = m_rd_known ? m_mem[idx] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (wen[b]) w[8*b +: 8] = wd[8*b +: 8];
                    m_mem[idx] = w;
                end
            end else begin
                m_rdata    = 32'h0;
                m_rd_known = 1'b1;
            end
        end
        if (en && !inr) m_err = 1'b1;
        else if (clr)   m_err = 1'b0;
    endtask

    task automatic apply(input logic en, input logic [3:0] wen, input logic [31:0] a,
                         input logic [31:0] wd, input logic clr);
        data_sram_en    = en;
        data_sram_wen   = wen;
        data_sram_addr  = a;
        data_sram_wdata = wd;
        err_clr         = clr;
        model_edge(en, wen, a, wd, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string name);
        check({name, "_err"}, {31'h0, err_oob}, {31'h0, m_err});
        if (m_rd_known) check({name, "_rdata"}, data_sram_rdata, m_rdata);
    endtask

    initial begin
        resetn          = 1'b0;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'h0;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        err_clr         = 1'b0;
        model_reset();

        //              en    wen    addr          wdata         clr   chk   exp_rd        exp_err
        tv[0]  = '{1'b1, 4'hF, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0,         1'b0};
        tv[1]  = '{1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,         1'b0};
        tv[2]  = '{1'b1, 4'h0, 32'h0000_0100, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0};
        tv[3]  = '{1'b0, 4'hF, 32'h0000_0100, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0};
        tv[4]  = '{1'b1, 4'h0, 32'h0000_0100, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0};
        tv[5]  = '{1'b1, 4'hF, 32'h0000_0008, 32'h1122_3344, 1'b0, 1'b0, 32'h0,         1'b0};
        tv[6]  = '{1'b1, 4'h5, 32'h0000_0008, 32'hAABB_CCDD, 1'b0, 1'b1, 32'h1122_3344, 1'b0};
        tv[7]  = '{1'b1, 4'h0, 32'h0000_0008, 32'h0,         1'b0, 1'b1, 32'h11BB_33DD, 1'b0};
        tv[8]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h0000_0001, 1'b0, 1'b0, 32'h0,         1'b0};
        tv[9]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h0000_0002, 1'b0, 1'b1, 32'h0000_0001, 1'b0};
        tv[10] = '{1'b1, 4'h0, 32'h0000_0022, 32'h0,         1'b0, 1'b1, 32'h0000_0002, 1'b0};
        tv[11] = '{1'b1, 4'hF, 32'h0004_0000, 32'h1234_5678, 1'b0, 1'b1, 32'h0,         1'b1};
        tv[12] = '{1'b1, 4'h0, 32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D, 1'b1};
        tv[13] = '{1'b1, 4'h0, 32'h0000_0100, 32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0};
        tv[14] = '{1'b1, 4'hF, 32'hFFFF_FFFC, 32'h0000_0001, 1'b0, 1'b1, 32'h0,         1'b1};
        tv[15] = '{1'b1, 4'h0, 32'h0004_0000, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1};
        tv[16] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0};
        tv[17] = '{1'b1, 4'hF, 32'h0003_FFFC, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0,         1'b0};
        tv[18] = '{1'b1, 4'h0, 32'h0003_FFFC, 32'h0,         1'b0, 1'b1, 32'hA5A5_A5A5, 1'b0};
        tv[19] = '{1'b1, 4'h0, 32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D, 1'b0};

        @(posedge clk);
        #1;
        check("reset_rdata", data_sram_rdata, 32'h0);
        check("reset_err", {31'h0, err_oob}, 32'h0);
`ifdef DSRAM_PERF_CNT_EN
        check("reset_rd_cnt", rd_cnt, 32'h0);
        check("reset_wr_cnt", wr_cnt, 32'h0);
`endif
        resetn = 1'b1;

        for (int i = 0; i < 20; i++) begin
            apply(tv[i].en, tv[i].wen, tv[i].addr, tv[i].wdata, tv[i].clr);
            if (tv[i].chk) check($sformatf("vec%0d_rdata", i), data_sram_rdata, tv[i].exp_rd);
            check($sformatf("vec%0d_err", i), {31'h0, err_oob}, {31'h0, tv[i].exp_err});
        end

        // Reset asserted in the middle of a write burst.
        apply(1'b1, 4'hF, 32'h4, 32'h55, 1'b0);
        apply(1'b1, 4'h0, 32'h0004_0000, 32'h0, 1'b0);
        apply(1'b1, 4'h0, 32'h4, 32'h0, 1'b0);
        check("pre_rst_rdata", data_sram_rdata, 32'h55);
        check("pre_rst_err", {31'h0, err_oob}, 32'h1);
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'hF;
        data_sram_addr  = 32'h4;
        data_sram_wdata = 32'h99;
        #1;
        resetn = 1'b0;
        #1;
        check("rst_async_rdata", data_sram_rdata, 32'h0);
        check("rst_async_err", {31'h0, err_oob}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_rdata", data_sram_rdata, 32'h0);
        check("rst_hold_err", {31'h0, err_oob}, 32'h0);
`ifdef DSRAM_PERF_CNT_EN
        check("rst_hold_rd_cnt", rd_cnt, 32'h0);
        check("rst_hold_wr_cnt", wr_cnt, 32'h0);
`endif
        resetn = 1'b1;
        model_reset();
        apply(1'b1, 4'h0, 32'h4, 32'h0, 1'b0);
        check("post_rst_rdata", data_sram_rdata, 32'h55);
`ifdef DSRAM_PERF_CNT_EN
        apply(1'b1, 4'h0, 32'h8, 32'h0, 1'b0);
        apply(1'b1, 4'h0, 32'h100, 32'h0, 1'b0);
        apply(1'b1, 4'hF, 32'h200, 32'h1, 1'b0);
        apply(1'b1, 4'h3, 32'h204, 32'h2, 1'b0);
        apply(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        check("cnt_rd", rd_cnt, 32'd3);
        check("cnt_wr", wr_cnt, 32'd2);
`endif

        // Randomized traffic against the reference model.
        #2;
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        model_reset();
        for (int w = 0; w < 16; w++) begin
            apply(1'b1, 4'hF, (32'h40 + 32'(w)) * 4, $urandom, 1'b0);
            check_model("init");
        end
        for (int n = 0; n < 400; n++) begin
            logic        r_en;
            logic [3:0]  r_wen;
            logic [31:0] r_addr;
            logic        r_clr;
            r_en   = ($urandom % 5) != 0;
            r_wen  = 4'($urandom % 16);
            r_clr  = ($urandom % 4) == 0;
            if (($urandom % 8) == 0) r_addr = $urandom | 32'h0004_0000;
            else                     r_addr = (32'h40 + ($urandom % 16)) * 4 + ($urandom % 4);
            apply(r_en, r_wen, r_addr, $urandom, r_clr);
            check_model($sformatf("rnd%0d", n));
        end
`ifdef DSRAM_PERF_CNT_EN
        check("rnd_rd_cnt", rd_cnt, 32'(m_rd_cnt));
        check("rnd_wr_cnt", wr_cnt, 32'(m_wr_cnt));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
